// File: rtl/y86_pred_pkg.sv
// Shared definitions for the Y86 fetch-stage PC predictor: the icode values the
// predictor decodes, the default PC width and the PC type.
package y86_pred_pkg;

    localparam int DEF_PC_W = 48;

    typedef logic [DEF_PC_W-1:0] pc_t;

    localparam logic [7:0] IJXX  = 8'd7;
    localparam logic [7:0] ICALL = 8'd8;
    localparam logic [7:0] IRET  = 8'd9;

endpackage

// File: rtl/pred_pc_unit_if.sv
// Fetch/redirect bus of the PC predictor. The master side is the fetch and
// hazard logic that drives fetch fields and redirects; the slave side is the predictor.
interface pred_pc_unit_if
    import y86_pred_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int RAS_DEPTH = 8
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic             F_stall_i;
    logic [7:0]       f_icode_i;
    logic [PC_W-1:0]  f_valC_i;
    logic [PC_W-1:0]  f_valP_i;
    logic             M_mispred_i;
    logic [PC_W-1:0]  M_valA_i;
    logic             W_call_i;
    logic             W_ret_i;
    logic             W_retmis_i;
    logic [PC_W-1:0]  W_valM_i;
    logic [PC_W-1:0]  F_predPC_o;
    logic             f_ras_hit_o;
    logic [CNT_W-1:0] ras_count_o;

    modport master (
        output F_stall_i, f_icode_i, f_valC_i, f_valP_i, M_mispred_i, M_valA_i,
               W_call_i, W_ret_i, W_retmis_i, W_valM_i,
        input  F_predPC_o, f_ras_hit_o, ras_count_o
    );

    modport slave (
        input  F_stall_i, f_icode_i, f_valC_i, f_valP_i, M_mispred_i, M_valA_i,
               W_call_i, W_ret_i, W_retmis_i, W_valM_i,
        output F_predPC_o, f_ras_hit_o, ras_count_o
    );

endinterface

// File: rtl/pred_ras.sv
// Return-address stack: circular storage with a speculative pointer/count,
// which fetch moves, and a committed pointer/count, which retirement moves.
// A restore copies the committed state, including this cycle's retirement, into
// the speculative state. Storage is not repaired on a restore.
module pred_ras
    import y86_pred_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int RAS_DEPTH = 8,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             restore_i,
    input  logic             w_call_i,
    input  logic             w_ret_i,
    input  logic [PC_W-1:0]  push_data_i,
    output logic [PC_W-1:0]  top_o,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, cp_q, cp_d, wr_ptr;
    logic [CNT_W-1:0] sc_q, sc_d, cc_q, cc_d;

    assign wr_ptr  = sp_q + 1'b1;
    assign top_o   = mem_q[sp_q];
    assign count_o = sc_q;

    // Committed state follows retirement; call and ret together is illegal and holds.
    always_comb begin
        cp_d = cp_q;
        cc_d = cc_q;
        if (w_call_i && !w_ret_i) begin
            cp_d = cp_q + 1'b1;
            if (cc_q != FULL) cc_d = cc_q + 1'b1;
        end else if (w_ret_i && !w_call_i && cc_q != '0) begin
            cp_d = cp_q - 1'b1;
            cc_d = cc_q - 1'b1;
        end
    end

    // Speculative state: restore wins, then push, then pop.
    always_comb begin
        sp_d = sp_q;
        sc_d = sc_q;
        if (restore_i) begin
            sp_d = cp_d;
            sc_d = cc_d;
        end else if (push_i) begin
            sp_d = wr_ptr;
            if (sc_q != FULL) sc_d = sc_q + 1'b1;
        end else if (pop_i && sc_q != '0) begin
            sp_d = sp_q - 1'b1;
            sc_d = sc_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
            sc_q <= '0;
            cp_q <= '0;
            cc_q <= '0;
        end else begin
            sp_q <= sp_d;
            sc_q <= sc_d;
            cp_q <= cp_d;
            cc_q <= cc_d;
        end
    end

    // Storage write. A full push overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (push_i && !restore_i) mem_q[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/pred_pc_unit.sv
// Fetch-stage predicted-PC register for the Y86 pipeline.
// Optional feature macro: PRED_RAS_EN builds the return-address stack; without it
// ret predicts fall-through and every retiring ret redirects.
module pred_pc_unit
    import y86_pred_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           rst,
    pred_pc_unit_if.slave bus
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic            w_redir, redir, ras_hit;
    logic [PC_W-1:0] ras_top;

    assign redir = w_redir | bus.M_mispred_i;

`ifdef PRED_RAS_EN
    logic ras_push, ras_pop;

    assign w_redir  = bus.W_ret_i & bus.W_retmis_i;
    assign ras_hit  = (bus.f_icode_i == IRET) && (bus.ras_count_o != '0);
    assign ras_push = !redir && !bus.F_stall_i && (bus.f_icode_i == ICALL);
    assign ras_pop  = !redir && !bus.F_stall_i && ras_hit;

    pred_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .restore_i   (redir),
        .w_call_i    (bus.W_call_i),
        .w_ret_i     (bus.W_ret_i),
        .push_data_i (bus.f_valP_i),
        .top_o       (ras_top),
        .count_o     (bus.ras_count_o)
    );
`else
    logic unused_ras;

    assign w_redir         = bus.W_ret_i;
    assign ras_hit         = 1'b0;
    assign ras_top         = '0;
    assign bus.ras_count_o = '0;
    assign unused_ras      = ^{bus.W_call_i, bus.W_retmis_i, ras_top};
`endif

    assign bus.f_ras_hit_o = ras_hit;
    assign bus.F_predPC_o  = pc_q;

    // Next-PC select: redirects, then stall, then fetch-based prediction.
    always_comb begin
        pc_d = pc_q;
        if (w_redir)
            pc_d = bus.W_valM_i;
        else if (bus.M_mispred_i)
            pc_d = bus.M_valA_i;
        else if (!bus.F_stall_i) begin
            if (bus.f_icode_i == IJXX || bus.f_icode_i == ICALL)
                pc_d = bus.f_valC_i;
            else if (ras_hit)
                pc_d = ras_top;
            else
                pc_d = bus.f_valP_i;
        end
    end

    // Predicted PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

endmodule

// File: tb/tb_pred_pc_unit.sv
// Directed bench for pred_pc_unit. Expected values are written out by hand; where
// they depend on PRED_RAS_EN the two outcomes are selected by RAS_EN.
module tb_pred_pc_unit;
    import y86_pred_pkg::*;

`ifdef PRED_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam logic [7:0] INOP = 8'd1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pred_pc_unit_if #(.PC_W(48), .RAS_DEPTH(8)) bus ();

    pred_pc_unit #(.PC_W(48), .RAS_DEPTH(8), .RESET_PC(48'h100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.F_stall_i   = 1'b0;
        bus.f_icode_i   = INOP;
        bus.f_valC_i    = '0;
        bus.f_valP_i    = '0;
        bus.M_mispred_i = 1'b0;
        bus.M_valA_i    = '0;
        bus.W_call_i    = 1'b0;
        bus.W_ret_i     = 1'b0;
        bus.W_retmis_i  = 1'b0;
        bus.W_valM_i    = '0;
    endtask

    task automatic fetch(input logic [7:0] ic, input pc_t c, input pc_t p);
        idle();
        bus.f_icode_i = ic;
        bus.f_valC_i  = c;
        bus.f_valP_i  = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        chk("reset_pc", bus.F_predPC_o, 48'h100);
        chk("reset_cnt", bus.ras_count_o, 0);
        rst = 1'b1;

        fetch(IJXX, 48'h40, 48'h9);
        tick();
        chk("jxx_pc", bus.F_predPC_o, 48'h40);

        fetch(ICALL, 48'h80, 48'h15);
        tick();
        chk("call_pc", bus.F_predPC_o, 48'h80);
        chk("call_cnt", bus.ras_count_o, RAS_EN ? 1 : 0);

        fetch(IRET, 48'h0, 48'h81);
        #1;
        chk("ret_hit", bus.f_ras_hit_o, RAS_EN ? 1 : 0);
        tick();
        chk("ret_pc", bus.F_predPC_o, RAS_EN ? 48'h15 : 48'h81);
        chk("ret_cnt", bus.ras_count_o, 0);

        fetch(IRET, 48'h0, 48'h82);
        #1;
        chk("empty_hit", bus.f_ras_hit_o, 0);
        tick();
        chk("empty_pc", bus.F_predPC_o, 48'h82);

        fetch(ICALL, 48'h999, 48'h777);
        bus.F_stall_i = 1'b1;
        tick();
        chk("stall_pc", bus.F_predPC_o, 48'h82);
        chk("stall_cnt", bus.ras_count_o, 0);

        // Nine calls into an eight-deep stack: 0x200 is overwritten.
        for (int i = 0; i < 9; i++) begin
            fetch(ICALL, 48'h500, 48'h200 + 48'(i));
            tick();
        end
        chk("full_cnt", bus.ras_count_o, RAS_EN ? 8 : 0);
        chk("full_pc", bus.F_predPC_o, 48'h500);
        for (int i = 0; i < 8; i++) begin
            fetch(IRET, 48'h0, 48'h900 + 48'(i));
            #1;
            chk("pop_hit", bus.f_ras_hit_o, RAS_EN ? 1 : 0);
            tick();
            chk("pop_pc", bus.F_predPC_o, RAS_EN ? 48'h208 - 48'(i) : 48'h900 + 48'(i));
        end
        chk("drain_cnt", bus.ras_count_o, 0);
        fetch(IRET, 48'h0, 48'hA00);
        #1;
        chk("drained_hit", bus.f_ras_hit_o, 0);
        tick();
        chk("drained_pc", bus.F_predPC_o, 48'hA00);

        // Two retiring calls move only the committed state.
        idle();
        bus.W_call_i = 1'b1;
        repeat (2) tick();
        chk("wcall_cnt", bus.ras_count_o, 0);

        // Stall, M redirect and W redirect together; W wins, ret retires (commit 2->1).
        fetch(ICALL, 48'h123, 48'h456);
        bus.F_stall_i   = 1'b1;
        bus.M_mispred_i = 1'b1;
        bus.M_valA_i    = 48'h22;
        bus.W_ret_i     = 1'b1;
        bus.W_retmis_i  = 1'b1;
        bus.W_valM_i    = 48'h300;
        tick();
        chk("prec_pc", bus.F_predPC_o, 48'h300);
        chk("prec_cnt", bus.ras_count_o, RAS_EN ? 1 : 0);

        // Correctly predicted ret retires alongside an M redirect (commit 1->0).
        idle();
        bus.M_mispred_i = 1'b1;
        bus.M_valA_i    = 48'h22;
        bus.W_ret_i     = 1'b1;
        bus.W_valM_i    = 48'h300;
        tick();
        chk("retok_pc", bus.F_predPC_o, RAS_EN ? 48'h22 : 48'h300);
        chk("retok_cnt", bus.ras_count_o, 0);

        // Committed count 1, two wrong-path calls, then a mispredict restores.
        idle();
        bus.W_call_i = 1'b1;
        tick();
        fetch(ICALL, 48'h700, 48'h600);
        tick();
        fetch(ICALL, 48'h700, 48'h601);
        tick();
        chk("wrong_cnt", bus.ras_count_o, RAS_EN ? 2 : 0);
        fetch(ICALL, 48'h700, 48'h602);
        bus.M_mispred_i = 1'b1;
        bus.M_valA_i    = 48'h60;
        tick();
        chk("recov_pc", bus.F_predPC_o, 48'h60);
        chk("recov_cnt", bus.ras_count_o, RAS_EN ? 1 : 0);

        // Mid-run asynchronous reset, then the first update after release.
        idle();
        rst = 1'b0;
        #1;
        chk("arst_pc", bus.F_predPC_o, 48'h100);
        chk("arst_cnt", bus.ras_count_o, 0);
        @(negedge clk);
        rst = 1'b1;
        fetch(INOP, 48'h0, 48'h10);
        tick();
        chk("post_rst_pc", bus.F_predPC_o, 48'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pred_pc_unit.md
# pred_pc_unit

Parametrised fetch-stage PC predictor for the Y86 pipeline. It holds the predicted PC register: jXX and call go to valC, ret goes to the top of a return-address stack (RAS), and everything else goes to valP. It takes redirects from the M stage (mispredicted jXX) and the W stage (ret resolution). It sits at the front of F, driving the PC select mux, with the hazard unit supplying stall and redirect controls.

## Interface
- `PC_W`, 48: PC/word width in bits.
- `RAS_DEPTH`, 8: RAS entries; power of two, 2..64.
- `RESET_PC`, 0: value loaded into the predicted PC at reset.

- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (asserted at 0).
- `F_stall_i` input 1: hold predicted PC and speculative RAS.
- `f_icode_i` input 8: icode of the instruction fetched this cycle.
- `f_valC_i` input PC_W: constant field, which is the jXX/call target.
- `f_valP_i` input PC_W: fall-through PC.
- `M_mispred_i` input 1: jXX in M was not taken.
- `M_valA_i` input PC_W: correct fall-through for a mispredicted jXX.
- `W_call_i` input 1: call retiring in W.
- `W_ret_i` input 1: ret retiring in W.
- `W_retmis_i` input 1: retiring ret's predicted target was wrong.
- `W_valM_i` input PC_W: actual return address.
- `F_predPC_o` output PC_W: predicted PC, registered.
- `f_ras_hit_o` output 1: fetched ret was predicted from the RAS (combinational).
- `ras_count_o` output $clog2(RAS_DEPTH+1): speculative RAS occupancy.

## Operation
- Reset (asynchronous, `rst`=0) sets:
  - `F_predPC_o`=RESET_PC;
  - speculative and committed pointers = 0;
  - speculative and committed counts = 0;
  - RAS contents don't-care.
- Next-PC priority, highest first:
  1. W redirect: `W_ret_i`&`W_retmis_i` → `W_valM_i`.
  2. M redirect: `M_mispred_i` → `M_valA_i`.
  3. `F_stall_i` → hold.
  4. icode IJXX/ICALL → `f_valC_i`.
  5. IRET with count>0 → RAS top.
  6. Otherwise → `f_valP_i`.
- Redirects override `F_stall_i`.
- Speculative RAS, updated only when no redirect and no stall:
  - ICALL pushes `f_valP_i` at ptr+1, and count saturates at RAS_DEPTH.
  - IRET with count>0 pops.
  - IRET with count=0 makes no change and does not assert `f_ras_hit_o`.
- Full push wraps circularly and overwrites the oldest entry. No error is flagged.
- Committed pointer/count track `W_call_i` (push) and `W_ret_i` (pop, floor 0) every cycle, independent of stall.
  - `W_call_i` and `W_ret_i` both high is illegal; the design holds the committed state.
- On any redirect, speculative pointer/count load the committed values including this cycle's W update. Contents are not repaired.
  - Wrong-path corruption only degrades prediction; the W redirect guarantees correctness.
- Pointer arithmetic is modulo RAS_DEPTH.

## Timing
- `F_predPC_o` changes only on the `clk` rising edge (or asynchronously on reset). Latency from `f_*` inputs to `F_predPC_o` is 1 cycle.
- `f_ras_hit_o` is combinational from `f_icode_i` and the speculative count, valid in the same cycle.
- A redirect asserted in cycle N appears on `F_predPC_o` in cycle N+1. Fetch inputs in cycle N are discarded.
- A push in cycle N is visible as the RAS top in cycle N+1, so back-to-back call then ret predicts correctly.
- Reset deassertion is synchronised externally. The first update is at the first edge after release.

## Configuration
- `PRED_RAS_EN` defined: RAS built as above.
- `PRED_RAS_EN` undefined:
  - no RAS storage;
  - IRET predicts `f_valP_i`;
  - `f_ras_hit_o`=0;
  - `ras_count_o`=0;
  - `W_retmis_i` is ignored and treated as 1, so every `W_ret_i` redirects to `W_valM_i`. This matches the classic stall-on-ret scheme.

## Structure
- The shared package `y86_pred_pkg` holds:
  - icode constants IJXX=7, ICALL=8, IRET=9;
  - the default PC_W;
  - the `pc_t` typedef.
- One sub-module, `pred_ras`: storage, speculative and committed pointers, push/pop/restore. It is instantiated only under `PRED_RAS_EN`.

## Test plan
- Reset: `rst`=0 mid-run with RESET_PC=0x100 → `F_predPC_o`=0x100 immediately; `ras_count_o`=0.
- Jump/call: IJXX with valC=0x40, then ICALL with valC=0x80, valP=0x15 → predPC 0x40, then 0x80; count=1.
- Call/ret: ICALL valP=0x15, then IRET → `f_ras_hit_o`=1 and predPC=0x15; count back to 0.
- Empty and full RAS:
  - IRET with count=0 → predPC=valP, no hit.
  - 9 calls with depth 8 → count=8, oldest entry overwritten.
- Redirect precedence: `F_stall_i`=1, `M_mispred_i`=1 with valA=0x22, and `W_retmis_i`=1 with valM=0x300, all in the same cycle → predPC=0x300; speculative count = committed count.
- Mispredict recovery: committed count=1, two wrong-path calls, then `M_mispred_i` with valA=0x60 → predPC=0x60, count=1.
